// File: rtl/noc_flit_pkg.sv
// Shared flit layout, state encoding and flit builder for the add-node transmit path.
package noc_flit_pkg;
  localparam int unsigned FLIT_W  = 71;
  localparam int unsigned VALID_B = 70;
  localparam int unsigned HEAD_B  = 69;
  localparam int unsigned DEST_HI = 68;
  localparam int unsigned DEST_LO = 65;
  localparam int unsigned OPSEL_B = 64;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned DEST_W  = DEST_HI - DEST_LO + 1;

  localparam logic OPSEL_A     = 1'b0;
  localparam logic OPSEL_B_VAL = 1'b1;

  typedef enum logic [1:0] {IDLE, SEND_A, SEND_B} tx_state_t;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] a;
  } pair_t;

  localparam int unsigned PAIR_W = $bits(pair_t);

  function automatic flit_t make_flit(input logic [DEST_W-1:0] dest,
                                      input logic              opsel,
                                      input logic [DATA_W-1:0] data);
    flit_t f;
    f                   = '0;
    f[VALID_B]          = 1'b1;
    f[HEAD_B]           = 1'b1;
    f[DEST_HI:DEST_LO]  = dest;
    f[OPSEL_B]          = opsel;
    f[DATA_W-1:0]       = data;
    return f;
  endfunction
endpackage

// File: rtl/add_operand_tx_if.sv
// Producer-side operand handshake and router-side flit handshake of the injector.
interface add_operand_tx_if;
  import noc_flit_pkg::*;

  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DEST_W-1:0] op_dest;
  flit_t             flit_out;
  logic              flit_valid;
  logic              net_ready;

  // slave is the injector itself; master is the producer/router environment
  modport slave (
    input  op_valid, op_a, op_b, op_dest, net_ready,
    output op_ready, flit_out, flit_valid
  );

  modport master (
    output op_valid, op_a, op_b, op_dest, net_ready,
    input  op_ready, flit_out, flit_valid
  );
endinterface

// File: rtl/flit_pair_fifo.sv
// Show-ahead synchronous FIFO for operand pairs; pushes are refused while full.
module flit_pair_fifo #(
  parameter int unsigned WIDTH = 132,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // extra pointer bit distinguishes full from empty when the indices match
  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/add_operand_tx.sv
// Operand-pair injector: buffers (A, B, dest) pairs and serialises each as an A flit
// followed by a B flit onto the mesh, one registered flit per transfer.
module add_operand_tx
  import noc_flit_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  add_operand_tx_if.slave  bus,
  output logic             busy,
  output logic [CNT_W-1:0] pairs_sent
);
  tx_state_t         state_q, state_d;
  flit_t             flit_q, flit_d;
  logic [DEST_W-1:0] hold_dest, hold_dest_d;
  logic [DATA_W-1:0] hold_b, hold_b_d;
  pair_t             fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              cnt_inc;
  logic              xfer;

  flit_pair_fifo #(
    .WIDTH (PAIR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (bus.op_valid),
    .pop     (pop),
    .din     ({bus.op_dest, bus.op_b, bus.op_a}),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign xfer           = flit_q[VALID_B] && bus.net_ready;
  assign bus.op_ready   = !fifo_full;
  assign bus.flit_out   = flit_q;
  assign bus.flit_valid = flit_q[VALID_B];
  assign busy           = !fifo_empty || (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      flit_q     <= '0;
      hold_dest  <= '0;
      hold_b     <= '0;
      pairs_sent <= '0;
    end else begin
      state_q   <= state_d;
      flit_q    <= flit_d;
      hold_dest <= hold_dest_d;
      hold_b    <= hold_b_d;
      if (cnt_inc) pairs_sent <= pairs_sent + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    flit_d      = flit_q;
    hold_dest_d = hold_dest;
    hold_b_d    = hold_b;
    pop         = 1'b0;
    cnt_inc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = SEND_A;
        end
      end
      SEND_A: begin
        if (xfer) begin
          flit_d  = make_flit(hold_dest, OPSEL_B_VAL, hold_b);
          state_d = SEND_B;
        end
      end
      SEND_B: begin
        if (xfer) begin
          cnt_inc = 1'b1;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = SEND_A;
          end else begin
            flit_d  = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        flit_d  = '0;
        state_d = IDLE;
      end
    endcase
    // a pop always loads the A flit directly; only dest and B need holding
    if (pop) begin
      flit_d      = make_flit(fifo_dout.dest, OPSEL_A, fifo_dout.a);
      hold_dest_d = fifo_dout.dest;
      hold_b_d    = fifo_dout.b;
    end
  end
endmodule

// File: tb/tb_add_operand_tx.sv
// Self-checking bench for add_operand_tx: directed vectors, corner sequences and a
// random run scored against a queue-based model of the expected flit stream.
module tb_add_operand_tx;
  import noc_flit_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] pairs_sent;

  add_operand_tx_if bus ();

  add_operand_tx #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .busy       (busy),
    .pairs_sent (pairs_sent)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [70:0] ref_flit(input logic [3:0] dest, input logic sel,
                                           input logic [63:0] data);
    return {2'b11, dest, sel, data};
  endfunction

  // Model: every accepted pair appends its A and B flits; each transfer must match the head.
  logic [70:0] exp_q[$];
  int unsigned model_cnt = 0;
  int unsigned n_xfer = 0;
  logic        stalled = 1'b0;
  logic [70:0] stalled_flit;

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      model_cnt = 0;
      stalled   = 1'b0;
    end else begin
      check("pairs_sent_model", pairs_sent, model_cnt % (2 ** CNT_W));
      if (!bus.flit_valid) check("idle_flit_zero", bus.flit_out, 0);
      if (stalled) check("hold_stable", bus.flit_out, stalled_flit);
      stalled      = bus.flit_valid && !bus.net_ready;
      stalled_flit = bus.flit_out;
      if (bus.flit_valid && bus.net_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_flit: got %0h expected none (t=%0t)", bus.flit_out, $time);
        end else begin
          logic [70:0] e;
          e = exp_q.pop_front();
          check("flit_order", bus.flit_out, e);
          if (e[64]) model_cnt++;
        end
      end
      if (bus.op_valid && bus.op_ready) begin
        exp_q.push_back(ref_flit(bus.op_dest, 1'b0, bus.op_a));
        exp_q.push_back(ref_flit(bus.op_dest, 1'b1, bus.op_b));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pair(input logic [63:0] a, input logic [63:0] b, input logic [3:0] d);
    bus.op_valid = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.op_dest  = d;
  endtask

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  dest;
    logic [70:0] exp_a;
    logic [70:0] exp_b;
    logic [64:0] exp_sum;
  } vec_t;

  vec_t        vecs[4];
  logic [63:0] got_a;
  logic [64:0] sum;
  logic [15:0] vhist, shist;
  int unsigned accepted;
  int unsigned base_xfer;

  initial begin
    vecs[0] = '{64'd5, 64'd7, 4'b0010, {2'b11, 4'b0010, 1'b0, 64'd5},
                {2'b11, 4'b0010, 1'b1, 64'd7}, 65'd12};
    vecs[1] = '{64'd0, 64'd0, 4'b0000, {2'b11, 4'b0000, 1'b0, 64'd0},
                {2'b11, 4'b0000, 1'b1, 64'd0}, 65'd0};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b1111,
                {2'b11, 4'b1111, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF},
                {2'b11, 4'b1111, 1'b1, 64'd1}, 65'h1_0000_0000_0000_0000};
    vecs[3] = '{64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_0F0F_0F0F, 4'b1010,
                {2'b11, 4'b1010, 1'b0, 64'h1234_5678_9ABC_DEF0},
                {2'b11, 4'b1010, 1'b1, 64'h0F0F_0F0F_0F0F_0F0F}, 65'h0_2143_6587_A9CB_EDFF};

    bus.op_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.op_dest   = '0;
    bus.net_ready = 1'b0;

    // reset held three cycles
    reset_n = 1'b0;
    repeat (3) begin
      tick();
      check("rst_flit_out", bus.flit_out, 0);
      check("rst_flit_valid", bus.flit_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_pairs_sent", pairs_sent, 0);
    end
    reset_n = 1'b1;
    check("op_ready_after_reset", bus.op_ready, 1);

    // single pairs from the vector table, net_ready high
    bus.net_ready = 1'b1;
    foreach (vecs[i]) begin
      drive_pair(vecs[i].a, vecs[i].b, vecs[i].dest);
      tick();
      bus.op_valid = 1'b0;
      tick();
      check("vec_a_flit", bus.flit_out, vecs[i].exp_a);
      got_a = bus.flit_out[63:0];
      tick();
      check("vec_b_flit", bus.flit_out, vecs[i].exp_b);
      sum = {1'b0, got_a} + {1'b0, bus.flit_out[63:0]};
      check("vec_sum", sum, vecs[i].exp_sum);
      tick();
      check("vec_idle", bus.flit_out, 0);
    end

    // A stalls three cycles, then transfers exactly once
    bus.net_ready = 1'b0;
    drive_pair(64'd11, 64'd22, 4'd9);
    tick();
    bus.op_valid = 1'b0;
    tick();
    repeat (3) begin
      check("stall_a_held", bus.flit_out, ref_flit(4'd9, 1'b0, 64'd11));
      tick();
    end
    bus.net_ready = 1'b1;
    tick();
    check("stall_then_b", bus.flit_out, ref_flit(4'd9, 1'b1, 64'd22));
    tick();
    check("stall_then_idle", bus.flit_valid, 0);

    // fill: DEPTH in FIFO plus one in holding, sixth offer refused
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    bus.net_ready = 1'b0;
    base_xfer = n_xfer;
    for (int i = 0; i < 6; i++) begin
      drive_pair(64'(100 + i), 64'(200 + i), 4'(i));
      check("fill_op_ready", bus.op_ready, (i < 5));
      tick();
    end
    bus.op_valid = 1'b0;
    check("fill_busy", busy, 1);
    check("fill_no_flit_sent", n_xfer - base_xfer, 0);
    bus.net_ready = 1'b1;
    for (int k = 0; k < 40 && pairs_sent != 5; k++) tick();
    check("fill_pairs_sent", pairs_sent, 5);
    repeat (3) tick();
    check("fill_flit_count", n_xfer - base_xfer, 10);
    check("fill_drained", busy, 0);

    // three back-to-back pairs stream with no gaps
    for (int c = 0; c < 16; c++) begin
      if (c < 3) drive_pair(64'(300 + c), 64'(400 + c), 4'd6);
      else bus.op_valid = 1'b0;
      tick();
      vhist[c] = bus.flit_valid;
      shist[c] = bus.flit_out[64];
    end
    check("stream_valid_run", vhist, 16'b0000_0000_0111_1110);
    check("stream_opsel_alt", shist, 16'b0000_0000_0101_0100);

    // reset after A transfers: B dropped, everything cleared
    drive_pair(64'd33, 64'd44, 4'd3);
    tick();
    bus.op_valid = 1'b0;
    tick();
    check("midpair_a", bus.flit_out, ref_flit(4'd3, 1'b0, 64'd33));
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("midpair_busy", busy, 0);
    check("midpair_pairs_sent", pairs_sent, 0);
    repeat (4) begin
      check("midpair_no_b", bus.flit_valid, 0);
      tick();
    end

    // counter wrap: 2^CNT_W + 1 pairs
    accepted = 0;
    for (int k = 0; k < 3000 && accepted < (2 ** CNT_W) + 1; k++) begin
      drive_pair({$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom));
      if (bus.op_ready) accepted++;
      tick();
    end
    bus.op_valid = 1'b0;
    for (int k = 0; k < 40 && busy; k++) tick();
    tick();
    check("wrap_accepted", accepted, (2 ** CNT_W) + 1);
    check("wrap_pairs_sent", pairs_sent, 1);

    // random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 1) == 1) drive_pair({$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom));
      else bus.op_valid = 1'b0;
      bus.net_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    bus.op_valid  = 1'b0;
    bus.net_ready = 1'b1;
    for (int k = 0; k < 60 && (busy || exp_q.size() != 0); k++) tick();
    tick();
    check("rand_queue_drained", exp_q.size(), 0);
    check("rand_busy_clear", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
